// File: rtl/mac_pfc_tx_ctrl_if.sv
// Byte-wide frame stream between a client, this controller and the TX MAC.
//   data  : frame byte
//   valid : byte present
//   sof   : first byte of a frame
//   eof   : last byte of a frame
//   ready : sink accepts the byte (qualified by the block's clk_en)
// master drives data/valid/sof/eof; slave drives ready.
interface mac_pfc_tx_ctrl_if;
  logic [7:0] data;
  logic       valid;
  logic       sof;
  logic       eof;
  logic       ready;

  modport master (output data, valid, sof, eof, input ready);
  modport slave  (input data, valid, sof, eof, output ready);
endinterface

// File: rtl/mac_pfc_tx_ctrl.sv
// Transmit-side MAC-control generator. Builds 802.3x PAUSE (20 B) or 802.1Qbb
// PFC (34 B) frames (DA/SA/type/opcode/payload; the MAC pads and appends FCS)
// and slots them between client frames on the byte path into the TX MAC.
// Frames go out on any change of xoff_req and, while XOFF holds, every
// refresh_thresh pause quanta.
//   clk, rst        : clock, synchronous active-high reset
//   clk_en          : byte-rate enable, all state holds while low
//   station_addr    : source address, [47:40] sent first
//   pfc_mode        : 0 PAUSE, 1 PFC (captured at frame start)
//   xoff_req/quanta : per-class level request and pause time
//   refresh_thresh  : quanta between refresh frames, 0 disables refresh
//   cl_tx           : client stream in (slave)
//   mac_tx          : stream to MAC (master)
//   pause_busy      : generated frame in progress
//   pause_sent      : pulse after the last generated byte is accepted
module mac_pfc_tx_ctrl #(
  parameter int NUM_CLASSES = 8,
  parameter int PRESCALE    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic [47:0]                station_addr,
  input  logic                       pfc_mode,
  input  logic [NUM_CLASSES-1:0]     xoff_req,
  input  logic [16*NUM_CLASSES-1:0]  quanta,
  input  logic [15:0]                refresh_thresh,
  mac_pfc_tx_ctrl_if.slave           cl_tx,
  mac_pfc_tx_ctrl_if.master          mac_tx,
  output logic                       pause_busy,
  output logic                       pause_sent
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {PASS, SEND} state_t;

  // Request state frozen at SEND entry, always padded out to 8 classes.
  typedef struct packed {
    logic             mode;
    logic [7:0]       req;
    logic [7:0]       chg;
    logic [7:0][15:0] q;
  } snap_t;

  state_t                 state;
  snap_t                  snap;
  logic                   pending, in_frame;
  logic [5:0]             byte_cnt;
  logic [15:0]            timer;
  logic [PW-1:0]          presc;
  logic [NUM_CLASSES-1:0] prev_req, chg_acc;

  // Live request padded to 8 classes; change mask covers everything since
  // the last frame so an XON held behind a client frame is still enabled.
  logic [7:0]       req8, chg8;
  logic [7:0][15:0] q8;
  always_comb begin
    req8 = '0;
    chg8 = '0;
    q8   = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      req8[i] = xoff_req[i];
      chg8[i] = chg_acc[i] | (xoff_req[i] ^ prev_req[i]);
      q8[i]   = quanta[16*i +: 16];
    end
  end

  // Triggers. Refresh fires on the tick the timer steps from 1 to 0, so an
  // idle (zero) timer never fires by itself.
  logic presc_wrap, chg_trig, refresh_trig;
  assign presc_wrap   = (presc == PW'(PRESCALE - 1));
  assign chg_trig     = clk_en & (|(xoff_req ^ prev_req));
  assign refresh_trig = clk_en & presc_wrap & (timer == 16'd1) &
                        (|xoff_req) & (refresh_thresh != 16'd0);

  // Generated frame byte at byte_cnt, from the snapshot.
  logic [15:0][7:0] hdr;
  logic [17:0][7:0] pfc_body;
  logic [3:0][7:0]  pause_body;
  logic [7:0][15:0] tfield;
  logic [7:0]       fbyte;
  logic [5:0]       last_idx;
  always_comb begin
    hdr = {48'h0180_C200_0001, station_addr, 16'h8808,
           (snap.mode ? 16'h0101 : 16'h0001)};
    for (int i = 0; i < 8; i++) tfield[i] = snap.req[i] ? snap.q[i] : 16'h0000;
    pause_body   = {tfield[0], 16'h0000};
    pfc_body     = '0;
    pfc_body[16] = snap.req | snap.chg;
    for (int i = 0; i < 8; i++) begin
      pfc_body[15-2*i] = tfield[i][15:8];
      pfc_body[14-2*i] = tfield[i][7:0];
    end
    last_idx = snap.mode ? 6'd33 : 6'd19;
    if (byte_cnt < 6'd16)  fbyte = hdr[4'(6'd15 - byte_cnt)];
    else if (snap.mode)    fbyte = pfc_body[5'(6'd33 - byte_cnt)];
    else                   fbyte = pause_body[2'(6'd19 - byte_cnt)];
  end

  // Stream mux. While a frame is pending outside a client frame the client
  // is stalled and nothing is offered, so a pause beats a new client sof.
  logic hold_off;
  assign hold_off = pending & ~in_frame;
  always_comb begin
    if (state == SEND) begin
      mac_tx.valid = 1'b1;
      mac_tx.data  = fbyte;
      mac_tx.sof   = (byte_cnt == 6'd0);
      mac_tx.eof   = (byte_cnt == last_idx);
      cl_tx.ready  = 1'b0;
    end else begin
      mac_tx.valid = cl_tx.valid & ~hold_off;
      mac_tx.data  = cl_tx.data;
      mac_tx.sof   = cl_tx.sof;
      mac_tx.eof   = cl_tx.eof;
      cl_tx.ready  = mac_tx.ready & ~hold_off;
    end
  end

  logic cl_acc, enter, done;
  assign cl_acc = (state == PASS) & clk_en & cl_tx.valid & mac_tx.ready & ~hold_off;
  assign enter  = (state == PASS) & clk_en & pending & (~in_frame | (cl_acc & cl_tx.eof));
  assign done   = (state == SEND) & clk_en & mac_tx.ready & (byte_cnt == last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PASS;
      snap       <= '0;
      pending    <= 1'b0;
      in_frame   <= 1'b0;
      byte_cnt   <= '0;
      timer      <= '0;
      presc      <= '0;
      prev_req   <= '0;
      chg_acc    <= '0;
      pause_busy <= 1'b0;
      pause_sent <= 1'b0;
    end else begin
      pause_sent <= done;
      if (clk_en) begin
        prev_req <= xoff_req;
        if (enter) begin
          pending <= 1'b0;
          chg_acc <= '0;
        end else begin
          if (chg_trig | refresh_trig) pending <= 1'b1;
          chg_acc <= chg_acc | (xoff_req ^ prev_req);
        end

        // Timer restarts from a full prescale period when a frame completes.
        if (done) begin
          timer <= (snap.mode ? |snap.req : snap.req[0]) ? refresh_thresh : 16'h0000;
          presc <= '0;
        end else begin
          presc <= presc_wrap ? '0 : presc + 1'b1;
          if (presc_wrap && timer != 16'd0) timer <= timer - 16'd1;
        end

        case (state)
          PASS: begin
            if (cl_acc) in_frame <= (in_frame | cl_tx.sof) & ~cl_tx.eof;
            if (enter) begin
              state      <= SEND;
              pause_busy <= 1'b1;
              byte_cnt   <= '0;
              snap.mode  <= pfc_mode;
              snap.req   <= req8;
              snap.chg   <= chg8;
              snap.q     <= q8;
            end
          end
          SEND: begin
            if (mac_tx.ready) begin
              if (byte_cnt == last_idx) begin
                state      <= PASS;
                pause_busy <= 1'b0;
                byte_cnt   <= '0;
              end else begin
                byte_cnt <= byte_cnt + 6'd1;
              end
            end
          end
          default: state <= PASS;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mac_pfc_tx_ctrl.sv
// Bench for mac_pfc_tx_ctrl: drives client/request stimulus, captures bytes
// accepted by the MAC and compares generated frames with a byte-list model
// built directly from the frame format.
module tb_mac_pfc_tx_ctrl;
  localparam int NC = 8;

  logic            clk = 1'b0;
  logic            rst, clk_en;
  logic [47:0]     sa;
  logic            pfc_mode;
  logic [NC-1:0]   xoff;
  logic [16*NC-1:0] quanta;
  logic [15:0]     thresh;
  logic            busy, sent;

  mac_pfc_tx_ctrl_if cl_if ();
  mac_pfc_tx_ctrl_if mac_if ();

  mac_pfc_tx_ctrl #(.NUM_CLASSES(NC), .PRESCALE(64)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .station_addr(sa), .pfc_mode(pfc_mode),
    .xoff_req(xoff), .quanta(quanta), .refresh_thresh(thresh),
    .cl_tx(cl_if), .mac_tx(mac_if), .pause_busy(busy), .pause_sent(sent)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, sent_cnt = 0, sent_cyc = 0, busy_rdy_err = 0, hold_err = 0;
  logic [7:0] cap_d[$];
  bit         cap_s[$], cap_e[$];
  int         cap_c[$];
  logic [7:0] exp_q[$];
  logic [NC-1:0] cur_req = '0;

  // Monitor: bytes presented here with valid&ready&clk_en are taken at the next edge.
  bit hold_chk = 0;
  logic [7:0] hd; logic hs, he;
  always @(negedge clk) begin
    cyc++;
    if (rst) hold_chk = 0;
    else begin
      if (clk_en && mac_if.valid && mac_if.ready) begin
        cap_d.push_back(mac_if.data); cap_s.push_back(mac_if.sof);
        cap_e.push_back(mac_if.eof);  cap_c.push_back(cyc);
      end
      if (sent) begin sent_cnt++; sent_cyc = cyc; end
      if (busy && cl_if.ready) busy_rdy_err++;
      if (hold_chk && (mac_if.data !== hd || mac_if.sof !== hs || mac_if.eof !== he)) hold_err++;
      hold_chk = busy && mac_if.valid && !(clk_en && mac_if.ready);
      hd = mac_if.data; hs = mac_if.sof; he = mac_if.eof;
    end
  end

  function automatic void cap_clear();
    cap_d = {}; cap_s = {}; cap_e = {}; cap_c = {}; hold_err = 0;
  endfunction

  // Reference frame from the format rules.
  task automatic build_exp(input bit m, input logic [NC-1:0] r, input logic [NC-1:0] c);
    logic [15:0] t;
    logic [7:0]  en;
    exp_q = {};
    exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'hC2);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    for (int k = 0; k < 6; k++) exp_q.push_back(sa[47-8*k -: 8]);
    exp_q.push_back(8'h88); exp_q.push_back(8'h08);
    if (!m) begin
      exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      t = r[0] ? quanta[15:0] : 16'h0;
      exp_q.push_back(t[15:8]); exp_q.push_back(t[7:0]);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    end else begin
      exp_q.push_back(8'h01); exp_q.push_back(8'h01);
      en = 8'(r | c);
      exp_q.push_back(8'h00); exp_q.push_back(en);
      for (int i = 0; i < 8; i++) begin
        t = (i < NC && r[i]) ? quanta[16*i +: 16] : 16'h0;
        exp_q.push_back(t[15:8]); exp_q.push_back(t[7:0]);
      end
    end
  endtask

  task automatic fire(input logic [NC-1:0] r, input bit m);
    @(posedge clk); #1;
    build_exp(m, r, cur_req ^ r);
    pfc_mode = m; xoff = r; cur_req = r;
    cap_clear();
  endtask

  // pat 0: always ready, 1: ready toggles 1010.., 2: random ready and clk_en.
  task automatic wait_sent(input int pat, input int maxc, input string nm);
    int start, n;
    start = sent_cnt; n = 0;
    while (sent_cnt == start && n < maxc) begin
      @(posedge clk); #1; n++;
      case (pat)
        1:       begin clk_en = 1; mac_if.ready = n[0]; end
        2:       begin clk_en = ($urandom_range(0, 3) != 0); mac_if.ready = $urandom_range(0, 1); end
        default: begin clk_en = 1; mac_if.ready = 1; end
      endcase
    end
    clk_en = 1; mac_if.ready = 1;
    if (sent_cnt == start) begin
      tests++; fails++;
      $display("FAIL %s timeout: no pause_sent within %0d cycles", nm, maxc);
    end
  endtask

  task automatic check_frame(input string nm, input int off);
    int bad, first, fbad, len;
    bad = 0; first = -1; fbad = 0;
    len = cap_d.size() - off;
    tests++;
    if (len !== exp_q.size()) begin
      fails++; $display("FAIL %s length: got %0d expected %0d", nm, len, exp_q.size());
    end
    for (int i = 0; i < len && i < exp_q.size(); i++)
      if (cap_d[off+i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s bytes: %0d wrong, first at %0d got %02h expected %02h",
               nm, bad, first, cap_d[off+first], exp_q[first]);
    end
    for (int i = 0; i < len; i++)
      if (cap_s[off+i] !== (i == 0) || cap_e[off+i] !== (i == len - 1)) fbad++;
    tests++;
    if (fbad != 0) begin fails++; $display("FAIL %s sof/eof: %0d bytes wrongly flagged, expected 0", nm, fbad); end
    tests++;
    if (hold_err != 0) begin fails++; $display("FAIL %s hold: %0d changes under backpressure, expected 0", nm, hold_err); end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; clk_en = 1; sa = 48'h0011_2233_4455; pfc_mode = 0; xoff = '0; quanta = '0;
    thresh = 0; mac_if.ready = 1;
    cl_if.valid = 0; cl_if.data = 0; cl_if.sof = 0; cl_if.eof = 0;
    idle(3); rst = 0;
    @(negedge clk);
    tests++; if (mac_if.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", mac_if.valid); end
    tests++; if (busy !== 1'b0 || sent !== 1'b0) begin fails++; $display("FAIL reset_flags: busy %b sent %b expected 0 0", busy, sent); end
    tests++; if (cl_if.ready !== 1'b1) begin fails++; $display("FAIL reset_ready_pass: got %b expected 1", cl_if.ready); end
    #1; mac_if.ready = 0; cl_if.valid = 1; cl_if.data = 8'hA5;
    @(negedge clk);
    tests++; if (cl_if.ready !== 1'b0) begin fails++; $display("FAIL reset_ready_follow: got %b expected 0", cl_if.ready); end
    tests++; if (mac_if.valid !== 1'b1 || mac_if.data !== 8'hA5) begin
      fails++; $display("FAIL reset_pass_data: got %b/%02h expected 1/a5", mac_if.valid, mac_if.data); end
    #1; cl_if.valid = 0; mac_if.ready = 1;
    idle(2);
  endtask

  task automatic test_pause_basic;
    int s0;
    quanta[15:0] = 16'hFFFF;
    s0 = sent_cnt;
    fire('h1, 0);
    wait_sent(0, 200, "pause_basic");
    check_frame("pause_basic", 0);
    idle(20);
    tests++; if (sent_cnt - s0 !== 1) begin fails++; $display("FAIL pause_sent_once: got %0d pulses expected 1", sent_cnt - s0); end
  endtask

  task automatic test_pfc;
    quanta = {$urandom, $urandom, $urandom, $urandom};
    fire('h0, 1);                          // XON for class 0
    wait_sent(0, 200, "pfc_xon");
    check_frame("pfc_xon", 0);
    idle(4);
    quanta[15:0] = 16'h0010; quanta[47:32] = 16'h0020;
    fire('h05, 1);
    wait_sent(0, 200, "pfc_basic");
    check_frame("pfc_basic", 0);
    idle(4);
  endtask

  task automatic test_back_to_back;
    int i, n, cbad;
    bit fired;
    i = 0; n = 0; cbad = 0; fired = 0;
    cap_clear();
    while (i < 64 && n < 500) begin
      @(posedge clk); #1; n++;
      cl_if.valid = 1; cl_if.data = 8'(i); cl_if.sof = (i == 0); cl_if.eof = (i == 63);
      if (i == 10 && !fired) begin
        build_exp(0, cur_req ^ 'h1, 'h1);
        xoff = cur_req ^ 'h1; pfc_mode = 0; cur_req = xoff; fired = 1;
      end
      @(negedge clk);
      if (cl_if.ready) i++;
    end
    @(posedge clk); #1;
    cl_if.valid = 0; cl_if.sof = 0; cl_if.eof = 0;
    wait_sent(0, 200, "back_to_back");
    for (int k = 0; k < 64; k++)
      if (k >= cap_d.size() || cap_d[k] !== 8'(k) || cap_s[k] !== (k == 0) || cap_e[k] !== (k == 63)) cbad++;
    tests++; if (cbad != 0) begin fails++; $display("FAIL client_intact: %0d bad bytes expected 0", cbad); end
    tests++;
    if (cap_c.size() < 65 || cap_c[64] - cap_c[63] !== 1) begin
      fails++; $display("FAIL pause_after_eof: gap %0d expected 1", (cap_c.size() < 65) ? -1 : cap_c[64] - cap_c[63]);
    end
    check_frame("back_to_back", 64);
    tests++; if (busy_rdy_err != 0) begin fails++; $display("FAIL ready_in_send: %0d cycles expected 0", busy_rdy_err); end
    idle(4);
  endtask

  task automatic test_backpressure;
    quanta = {$urandom, $urandom, $urandom, $urandom};
    fire(cur_req ^ 8'h81, 1);
    wait_sent(1, 300, "backpressure");
    check_frame("backpressure", 0);
    idle(4);
  endtask

  task automatic test_random;
    logic [NC-1:0] r;
    for (int it = 0; it < 6; it++) begin
      quanta = {$urandom, $urandom, $urandom, $urandom};
      r = NC'($urandom);
      if (r == cur_req) r[$urandom_range(0, NC-1)] ^= 1'b1;
      fire(r, 1'($urandom_range(0, 1)));
      wait_sent(2, 600, "random");
      check_frame("random", 0);
      idle(3);
    end
  endtask

  task automatic test_refresh;
    int t0, gap, s1;
    thresh = 0;
    if (cur_req != 0) begin
      fire('h0, 0); wait_sent(0, 200, "refresh_pre"); check_frame("refresh_pre", 0); idle(4);
    end
    thresh = 2; quanta[15:0] = 16'h1234;
    fire('h1, 0);
    wait_sent(0, 200, "refresh_first");
    check_frame("refresh_first", 0);
    t0 = sent_cyc;
    cap_clear();
    wait_sent(0, 400, "refresh_second");
    check_frame("refresh_second", 0);
    gap = (cap_c.size() > 0) ? cap_c[0] - t0 : -1;
    tests++; if (gap < 128 || gap > 132) begin fails++; $display("FAIL refresh_gap: got %0d expected 128..132", gap); end
    fire('h0, 0);
    wait_sent(0, 200, "refresh_xon");
    check_frame("refresh_xon", 0);
    s1 = sent_cnt;
    idle(300);
    tests++; if (sent_cnt !== s1) begin fails++; $display("FAIL refresh_stop: got %0d extra frames expected 0", sent_cnt - s1); end
    thresh = 0;
  endtask

  task automatic test_reset_mid_send;
    int n;
    logic [NC-1:0] r;
    r = 8'h3C;
    quanta = {$urandom, $urandom, $urandom, $urandom};
    fire(r, 1);
    n = 0;
    while (cap_d.size() < 8 && n < 200) begin @(posedge clk); #1; n++; end
    if (cap_d.size() < 8) begin tests++; fails++; $display("FAIL rst_mid timeout: got %0d bytes expected 8", cap_d.size()); end
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    tests++; if (mac_if.valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b expected 0", mac_if.valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    #1; rst = 0;
    cap_clear();
    build_exp(1, r, r);                     // requester restarts from prev_req = 0
    wait_sent(0, 200, "rst_mid_resend");
    check_frame("rst_mid_resend", 0);
  endtask

  initial begin
    test_reset;
    test_pause_basic;
    test_pfc;
    test_back_to_back;
    test_backpressure;
    test_random;
    test_refresh;
    test_reset_mid_send;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
